add_share_arb: RTL

- Round-robin arbiter and sequencer that shares one WIDTH-bit LUT adder datapath between NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes.
- Drives the shared adder's a/b inputs and waits ADD_LAT cycles for y.
- Returns the sum tagged with the requester id over a single response handshake.
- Sits between client logic and the adder (module main); exactly one operation in flight.

---
 rtl/add_share_arb_pkg.sv | 30 +++
 rtl/add_share_rr_sel.sv | 39 +++
 rtl/add_share_arb.sv | 135 +++++++++++++
 3 files changed

// File: rtl/add_share_arb_pkg.sv
// Shared types and the round-robin pick function for the add_share_arb slice.
package add_share_arb_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int MAX_REQ = 8;
    localparam int PTR_W   = 3;

    // One-hot grant: first valid requester scanning ptr, ptr+1, ... wrapping mod nreq.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [PTR_W-1:0]   ptr,
        input int                 nreq
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        grant = '0;
        found = 1'b0;
        for (int off = 0; off < MAX_REQ; off++) begin
            idx = (int'(ptr) + off) % nreq;
            if (off < nreq && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/add_share_rr_sel.sv
// Combinational round-robin selector: one-hot grant, its index, and any-valid.
module add_share_rr_sel
    import add_share_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    logic [MAX_REQ-1:0] pick;
    logic [IDW-1:0]     id_terms [NREQ];
    logic               unused_pick;

    assign pick        = rr_pick(MAX_REQ'(req_valid), PTR_W'(rr_ptr), NREQ);
    assign grant       = pick[NREQ-1:0];
    assign any         = |req_valid;
    assign unused_pick = ^pick;

    // grant is one-hot, so OR-ing the masked indices yields the encoded id
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_enc
            assign id_terms[gi] = grant[gi] ? IDW'(gi) : '0;
        end
    endgenerate

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_id = grant_id | id_terms[i];
        end
    end

endmodule

// File: rtl/add_share_arb.sv
// Round-robin sequencer sharing one adder between NREQ requesters, one op in flight.
// Define ADD_SHARE_ARB_SELFCHECK_EN to compare add_y against a local sum (sticky chk_err).
module add_share_arb
    import add_share_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [WIDTH-1:0]          add_a,
    output logic [WIDTH-1:0]          add_b,
    input  logic [WIDTH-1:0]          add_y,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]          rsp_y,
    output logic                      chk_err
);

    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

    state_t            state_reg;
    logic [IDW-1:0]    rr_ptr_reg;
    logic [IDW-1:0]    id_q_reg;
    logic [CNTW-1:0]   cnt_reg;
    logic [WIDTH-1:0]  add_a_reg;
    logic [WIDTH-1:0]  add_b_reg;
    logic              rsp_valid_reg;
    logic [IDW-1:0]    rsp_id_reg;
    logic [WIDTH-1:0]  rsp_y_reg;

    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_id;
    logic              any;
    logic [WIDTH-1:0]  op_a [NREQ];
    logic [WIDTH-1:0]  op_b [NREQ];

    add_share_rr_sel #(.NREQ(NREQ), .IDW(IDW)) u_sel (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_reg),
        .grant     (grant),
        .grant_id  (grant_id),
        .any       (any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ops
            assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
            assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Ready is only offered in IDLE and never while reset is held low
    assign req_ready = (state_reg == IDLE && reset) ? grant : '0;

`ifdef ADD_SHARE_ARB_SELFCHECK_EN
    logic              chk_err_reg;
    logic [WIDTH-1:0]  sum_local;
    assign sum_local = add_a_reg + add_b_reg;
    assign chk_err   = chk_err_reg;
`else
    assign chk_err   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            id_q_reg      <= '0;
            cnt_reg       <= '0;
            add_a_reg     <= '0;
            add_b_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_y_reg     <= '0;
`ifdef ADD_SHARE_ARB_SELFCHECK_EN
            chk_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any) begin
                        add_a_reg <= op_a[grant_id];
                        add_b_reg <= op_b[grant_id];
                        id_q_reg  <= grant_id;
                        cnt_reg   <= CNTW'(ADD_LAT);
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        rsp_y_reg     <= add_y;
                        rsp_id_reg    <= id_q_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
`ifdef ADD_SHARE_ARB_SELFCHECK_EN
                        if (add_y != sum_local) begin
                            chk_err_reg <= 1'b1;
`ifndef SYNTHESIS
                            $error("add_share_arb: id=%0d a=%0h b=%0h y=%0h expected=%0h",
                                   id_q_reg, add_a_reg, add_b_reg, add_y, sum_local);
`endif
                        end
`endif
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rr_ptr_reg    <= (id_q_reg == IDW'(NREQ - 1)) ? '0 : id_q_reg + 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign add_a     = add_a_reg;
    assign add_b     = add_b_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_y     = rsp_y_reg;

endmodule
